acc_cpu_core: RTL



---
 rtl/acc_cpu_pkg.sv | 51 +++++
 rtl/acc_cpu_alu.sv | 59 +++++
 rtl/acc_cpu_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU core: opcode and FSM state enums,
// the immediate-select bit position, and the branch-offset sign extender.
// Latency: none (types and a pure function). Backpressure: not applicable.
package acc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_GET  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BR   = 4'hC,
    OP_CMP  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_LDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int LI_BIT = 8;
  localparam int SEXT_W = 32;

  // Sign-extend the low src_w bits of val to SEXT_W bits. The caller
  // truncates the result to the PC width, which gives modulo-2^PCW offsets.
  function automatic logic [SEXT_W-1:0] sext_off(input logic [SEXT_W-1:0] val,
                                                 input int src_w);
    logic [SEXT_W-1:0] res;
    logic              sgn;
    sgn = 1'b0;
    for (int i = 0; i < SEXT_W; i++) begin
      if (i == src_w - 1) sgn = val[i];
    end
    for (int i = 0; i < SEXT_W; i++) begin
      res[i] = (i < src_w) ? val[i] : sgn;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for opcodes ADD..SHR of the accumulator CPU.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_op opcode, i_acc accumulator, i_opd register operand, i_cin
//        current carry; o_result new acc, o_cout new carry, o_zero result==0.
// Opcodes outside ADD..SHR pass acc and carry through unchanged.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  opcode_t         i_op,
  input  logic [DW-1:0]   i_acc,
  input  logic [DW-1:0]   i_opd,
  input  logic            i_cin,
  output logic [DW-1:0]   o_result,
  output logic            o_cout,
  output logic            o_zero
);

  logic [DW:0] w_sum;
  logic [DW:0] w_dif;

  assign w_sum = {1'b0, i_acc} + {1'b0, i_opd};
  // Top bit of the widened difference is set exactly when acc < operand.
  assign w_dif = {1'b0, i_acc} - {1'b0, i_opd};

  always_comb begin
    o_result = i_acc;
    o_cout   = i_cin;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DW-1:0];
        o_cout   = w_sum[DW];
      end
      OP_SUB: begin
        o_result = w_dif[DW-1:0];
        o_cout   = w_dif[DW];
      end
      OP_AND: o_result = i_acc & i_opd;
      OP_OR:  o_result = i_acc | i_opd;
      OP_XOR: o_result = i_acc ^ i_opd;
      OP_SHL: begin
        o_result = {i_acc[DW-2:0], 1'b0};
        o_cout   = i_acc[DW-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_acc[DW-1:1]};
        o_cout   = i_acc[0];
      end
      default: begin
        o_result = i_acc;
        o_cout   = i_cin;
      end
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with Start/Ack run control and perf counters.
// Latency: LD takes 2 cycles (sync-read data memory), every other op 1 cycle.
// Backpressure: none; ROM is combinational, data memory has fixed 1-cycle read.
// Ports: Clk/Reset (sync, active-high), Start in, Ack out (DONE),
//        InstAddress/InstOut ROM, DataAddress/DataWrEn/DataWrite/DataRead
//        data memory, Busy (RUN or LDWAIT), CycleCt/InstrCt perf counters.
// Optional: define ACC_CPU_PERF_EN to build the saturating perf counters;
//           otherwise CycleCt and InstrCt are constant zero.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int              DW       = 8,
  parameter int              NREG     = 16,
  parameter int              PCW      = 10,
  parameter logic [PCW-1:0]  START_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic            Ack,
  output logic [PCW-1:0]  InstAddress,
  input  logic [8:0]      InstOut,
  output logic [DW-1:0]   DataAddress,
  output logic            DataWrEn,
  output logic [DW-1:0]   DataWrite,
  input  logic [DW-1:0]   DataRead,
  output logic            Busy,
  output logic [15:0]     CycleCt,
  output logic [15:0]     InstrCt
);

  localparam int ACC = NREG - 1;

  state_t           r_state;
  logic [PCW-1:0]   r_pc;
  logic [DW-1:0]    r_regs [NREG];
  logic             r_z;
  logic             r_c;
  logic             r_ack;
  logic             r_busy;

  logic             w_is_li;
  opcode_t          w_op;
  logic [3:0]       w_ridx;
  logic [DW-1:0]    w_acc;
  logic [DW-1:0]    w_opd;
  logic [PCW-1:0]   w_pc_inc;
  logic [PCW-1:0]   w_pc_br;
  logic [DW-1:0]    w_alu_result;
  logic             w_alu_cout;
  logic             w_alu_zero;
  logic             w_mem_phase;

  assign w_is_li  = InstOut[LI_BIT];
  assign w_op     = opcode_t'(InstOut[7:4]);
  assign w_ridx   = InstOut[3:0];
  assign w_acc    = r_regs[ACC];
  assign w_opd    = r_regs[w_ridx];
  assign w_pc_inc = r_pc + PCW'(1);
  assign w_pc_br  = r_pc + PCW'(sext_off(SEXT_W'(w_opd), DW));

  acc_cpu_alu #(.DW(DW)) u_alu (
    .i_op     (w_op),
    .i_acc    (w_acc),
    .i_opd    (w_opd),
    .i_cin    (r_c),
    .o_result (w_alu_result),
    .o_cout   (w_alu_cout),
    .o_zero   (w_alu_zero)
  );

  assign w_mem_phase = (r_state == S_RUN) || (r_state == S_LDWAIT);

  // A restart or reset in the store cycle cancels the store.
  assign DataWrEn    = (r_state == S_RUN) && !Start && !Reset && !w_is_li && (w_op == OP_ST);
  assign DataAddress = w_mem_phase ? w_opd : '0;
  assign DataWrite   = w_acc;
  assign InstAddress = r_pc;
  assign Ack         = r_ack;
  assign Busy        = r_busy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state <= S_RUN;
            r_pc    <= START_PC;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (Start) begin
            r_pc <= START_PC;
          end else if (w_is_li) begin
            r_regs[ACC] <= DW'(InstOut[7:0]);
            r_z         <= (InstOut[7:0] == 8'd0);
            r_pc        <= w_pc_inc;
          end else begin
            r_pc <= w_pc_inc;
            case (w_op)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                r_regs[ACC] <= w_alu_result;
                r_z         <= w_alu_zero;
                r_c         <= w_alu_cout;
              end
              OP_MOV:  r_regs[w_ridx] <= w_acc;
              OP_GET:  r_regs[ACC]    <= w_opd;
              OP_LD: begin
                // Address is presented this cycle; data lands next cycle.
                r_state <= S_LDWAIT;
                r_pc    <= r_pc;
              end
              OP_BEQ:  if (r_z) r_pc <= w_pc_br;
              OP_BR:   r_pc <= w_pc_br;
              OP_CMP:  r_z  <= (w_acc == w_opd);
              OP_HALT: begin
                r_state <= S_DONE;
                r_pc    <= r_pc;
                r_ack   <= 1'b1;
                r_busy  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_LDWAIT: begin
          r_regs[ACC] <= DataRead;
          r_z         <= (DataRead == '0);
          r_pc        <= w_pc_inc;
          r_state     <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ACC_CPU_PERF_EN
  logic [15:0] r_cycle_ct;
  logic [15:0] r_instr_ct;
  logic        w_start_acc;
  logic        w_retire;

  // Start is ignored while a load is completing, so it does not clear there.
  assign w_start_acc = Start && (r_state != S_LDWAIT);
  // LD retires in its wait cycle; HALT retires like any other instruction.
  assign w_retire    = ((r_state == S_RUN) && !(!w_is_li && (w_op == OP_LD)))
                     || (r_state == S_LDWAIT);

  always_ff @(posedge Clk) begin
    if (Reset || w_start_acc) begin
      r_cycle_ct <= '0;
      r_instr_ct <= '0;
    end else begin
      if (w_mem_phase && (r_cycle_ct != 16'hFFFF)) r_cycle_ct <= r_cycle_ct + 16'd1;
      if (w_retire && (r_instr_ct != 16'hFFFF))    r_instr_ct <= r_instr_ct + 16'd1;
    end
  end

  assign CycleCt = r_cycle_ct;
  assign InstrCt = r_instr_ct;
`else
  assign CycleCt = 16'd0;
  assign InstrCt = 16'd0;
`endif

endmodule
